// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-requester request/response bundle for the data memory arbiter
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ready0;
    logic        ready1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ready0, ready1, err0, err1, rdata0, rdata1
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ready0, ready1, err0, err1, rdata0, rdata1
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-way arbiter and access sequencer for the single-port data memory
module dmem_arbiter #(
    parameter int ADDR_WORDS = 256,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic          busy,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [31:0]   address,
    output logic [31:0]   write_data,
    input  logic [31:0]   read_data
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic        gnt;
    logic        gnt_we;
    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        addr_ok;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            sel = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            sel = bus.req1;
        end
        sel_we    = sel ? bus.we1    : bus.we0;
        sel_addr  = sel ? bus.addr1  : bus.addr0;
        sel_wdata = sel ? bus.wdata1 : bus.wdata0;
        addr_ok   = (sel_addr[1:0] == 2'b00) &&
                    ({2'b00, sel_addr[31:2]} < 32'(ADDR_WORDS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            gnt_we     <= 1'b0;
            busy       <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            address    <= 32'd0;
            write_data <= 32'd0;
            bus.ready0 <= 1'b0;
            bus.ready1 <= 1'b0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.rdata0 <= 32'd0;
            bus.rdata1 <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt        <= sel;
                        gnt_we     <= sel_we;
                        last_grant <= sel;
                        busy       <= 1'b1;
                        if (addr_ok) begin
                            state      <= S_ACCESS;
                            address    <= {2'b00, sel_addr[31:2]};
                            write_data <= sel_wdata;
                            MemRead    <= ~sel_we;
                            MemWrite   <= sel_we;
                        end else begin
                            // Rejected: complete immediately without touching memory.
                            state <= S_DONE;
                            if (sel) begin
                                bus.ready1 <= 1'b1;
                                bus.err1   <= 1'b1;
                                bus.rdata1 <= 32'd0;
                            end else begin
                                bus.ready0 <= 1'b1;
                                bus.err0   <= 1'b1;
                                bus.rdata0 <= 32'd0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    state    <= S_DONE;
                    if (gnt) begin
                        bus.ready1 <= 1'b1;
                        if (!gnt_we) bus.rdata1 <= read_data;
                    end else begin
                        bus.ready0 <= 1'b1;
                        if (!gnt_we) bus.rdata0 <= read_data;
                    end
                end
                S_DONE: begin
                    bus.ready0 <= 1'b0;
                    bus.ready1 <= 1'b0;
                    bus.err0   <= 1'b0;
                    bus.err1   <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fp_en = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bif();
    dmem_arbiter_if fif();

    logic        busy0, mr0, mw0, busy1, mr1, mw1;
    logic [31:0] address0, wd0, rd0, address1, wd1, rd1;
    logic [31:0] ram0 [0:255];
    logic [31:0] ram1 [0:255];
    logic [31:0] model [0:255];

    assign fif.req0   = fp_en & bif.req0;
    assign fif.req1   = fp_en & bif.req1;
    assign fif.we0    = bif.we0;
    assign fif.we1    = bif.we1;
    assign fif.addr0  = bif.addr0;
    assign fif.addr1  = bif.addr1;
    assign fif.wdata0 = bif.wdata0;
    assign fif.wdata1 = bif.wdata1;

    dmem_arbiter #(.ADDR_WORDS(256), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset), .bus(bif), .busy(busy0),
        .MemRead(mr0), .MemWrite(mw0), .address(address0),
        .write_data(wd0), .read_data(rd0)
    );
    dmem_arbiter #(.ADDR_WORDS(256), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset), .bus(fif), .busy(busy1),
        .MemRead(mr1), .MemWrite(mw1), .address(address1),
        .write_data(wd1), .read_data(rd1)
    );

    assign rd0 = ram0[address0[7:0]];
    assign rd1 = ram1[address1[7:0]];
    always @(posedge clk) if (mw0) ram0[address0[7:0]] <= wd0;
    always @(posedge clk) if (mw1) ram1[address1[7:0]] <= wd1;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int rdy_cnt = 0;
    logic [31:0] exp_rd [2];
    int rr_q[$];
    int fp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic bit addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'd256);
    endfunction

    function automatic logic rdy(input int k);
        return (k == 0) ? bif.ready0 : bif.ready1;
    endfunction

    // Completion rules applied at each ready: rejection zeroes rdata, writes update memory, reads return it.
    task automatic complete(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic err, input logic [31:0] rdata);
        bit ok;
        ok = addr_legal(a);
        chk(k == 0 ? "err0" : "err1", err, !ok);
        if (!ok) exp_rd[k] = 32'd0;
        else if (we) model[a[9:2]] = d;
        else exp_rd[k] = model[a[9:2]];
        chk(k == 0 ? "rdata0" : "rdata1", rdata, exp_rd[k]);
        rr_q.push_back(k);
        rdy_cnt++;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_rd[0] = 32'd0;
            exp_rd[1] = 32'd0;
        end else begin
            if (mr0 || mw0) begin
                stb_cnt++;
                chk("strobe_onehot", {31'd0, mr0 & mw0}, 32'd0);
            end
            if (bif.err0 && !bif.ready0) chk("err0_without_ready", 32'd1, 32'd0);
            if (bif.err1 && !bif.ready1) chk("err1_without_ready", 32'd1, 32'd0);
            if (bif.ready0) complete(0, bif.we0, bif.addr0, bif.wdata0, bif.err0, bif.rdata0);
            else chk("rdata0_hold", bif.rdata0, exp_rd[0]);
            if (bif.ready1) complete(1, bif.we1, bif.addr1, bif.wdata1, bif.err1, bif.rdata1);
            else chk("rdata1_hold", bif.rdata1, exp_rd[1]);
            if (fp_en && fif.ready0) begin
                fp_q.push_back(0);
                chk("fp_rdata0", fif.rdata0, init_val(int'(fif.addr0[9:2])));
            end
            if (fp_en && fif.ready1) begin
                fp_q.push_back(1);
                chk("fp_rdata1", fif.rdata1, init_val(int'(fif.addr1[9:2])));
            end
        end
    end

    task automatic drive(input int k, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (k == 0) begin
            bif.req0 = r; bif.we0 = we; bif.addr0 = a; bif.wdata0 = d;
        end else begin
            bif.req1 = r; bif.we1 = we; bif.addr1 = a; bif.wdata1 = d;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ready cycle, req still high.
    task automatic issue(input int k, input logic we, input logic [31:0] a, input logic [31:0] d, input bit solo);
        int lat;
        int s0;
        bit ok;
        ok = addr_legal(a);
        s0 = stb_cnt;
        drive(k, 1'b1, we, a, d);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (solo && ok && lat == 1) begin
                chk("strobe_write", {31'd0, mw0}, {31'd0, we});
                chk("strobe_read", {31'd0, mr0}, {31'd0, ~we});
                chk("mem_address", address0, {2'b00, a[31:2]});
                if (we) chk("mem_wdata", wd0, d);
            end
        end while (!rdy(k) && lat < 40);
        if (!rdy(k)) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (solo) chk("latency", 32'(lat), ok ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        if (solo) begin
            chk("ready_one_cycle", {31'd0, rdy(k)}, 32'd0);
            chk("strobe_cycles", 32'(stb_cnt - s0), ok ? 32'd1 : 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int p;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        p = $urandom_range(0, 7);
        if (p == 0) a = a | 32'($urandom_range(1, 3));
        else if (p == 1) a = 32'($urandom_range(256, 4000)) << 2;
        return a;
    endfunction

    task automatic rand_traffic(input int k, input int n, input bit solo);
        int gap;
        for (int i = 0; i < n; i++) begin
            issue(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom, solo);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) begin
            ram0[i] = init_val(i);
            ram1[i] = init_val(i);
            model[i] = init_val(i);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_reset();

        chk("rst_ready0", {31'd0, bif.ready0}, 32'd0);
        chk("rst_ready1", {31'd0, bif.ready1}, 32'd0);
        chk("rst_err", {30'd0, bif.err0, bif.err1}, 32'd0);
        chk("rst_strobes", {29'd0, mr0, mw0, busy0}, 32'd0);
        chk("rst_rdata0", bif.rdata0, 32'd0);
        chk("rst_rdata1", bif.rdata1, 32'd0);
        chk("rst_address", address0, 32'd0);
        chk("rst_write_data", wd0, 32'd0);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b0, 32'h10, 32'd0, 1'b1);
        chk("readback", bif.rdata0, 32'hDEADBEEF);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;

        issue(1, 1'b0, 32'h6, 32'd0, 1'b1);
        issue(1, 1'b0, 32'h400, 32'd0, 1'b1);
        chk("reject_rdata1", bif.rdata1, 32'd0);
        issue(1, 1'b0, 32'h3FC, 32'd0, 1'b1);
        chk("word255", bif.rdata1, init_val(255));
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        do_reset();
        fp_en = 1'b1;
        rr_q.delete();
        fp_q.delete();
        drive(0, 1'b1, 1'b0, 32'h50, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h54, 32'd0);
        repeat (12) @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        fp_en = 1'b0;
        chk("rr_grant_count", 32'(rr_q.size()), 32'd5);
        chk("fp_grant_count", 32'(fp_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rr_q.size()) chk("rr_grant_order", 32'(rr_q[i]), (i == 4) ? 32'd1 : 32'(i % 2));
            if (i < fp_q.size()) chk("fp_grant_order", 32'(fp_q[i]), (i == 4) ? 32'd1 : 32'd0);
        end

        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_access", {31'd0, mr0}, 32'd1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_ready", {31'd0, bif.ready0}, 32'd0);
        chk("rst_mid_strobes", {29'd0, mr0, mw0, busy0}, 32'd0);
        chk("rst_mid_rdata", bif.rdata0, 32'd0);
        chk("rst_mid_address", address0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_no_ready", {31'd0, bif.ready0}, 32'd0);
        issue(0, 1'b0, 32'h10, 32'd0, 1'b1);
        chk("reissue_rdata", bif.rdata0, 32'hDEADBEEF);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;

        base = rdy_cnt;
        for (int i = 0; i < 6; i++) issue(0, 1'($urandom_range(0, 1)), {22'd0, 8'(i * 7), 2'b00}, $urandom, 1'b1);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("b2b_completions", 32'(rdy_cnt - base), 32'd6);

        rand_traffic(0, 40, 1'b1);
        rand_traffic(1, 40, 1'b1);
        base = rdy_cnt;
        fork
            rand_traffic(0, 60, 1'b0);
            rand_traffic(1, 60, 1'b0);
        join
        repeat (4) @(posedge clk);
        #1 chk("dual_completions", 32'(rdy_cnt - base), 32'd120);
        for (int i = 0; i < 256; i++) chk("mem_contents", ram0[i], model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
